// File: rtl/bus_pkg.sv
// Shared types and constants for the 8051 external-bus responder.
package bus_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 15;

  localparam logic MEM_SPACE_CODE  = 1'b0;
  localparam logic MEM_SPACE_XDATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DRIVE,
    ST_WR_CAPT,
    ST_WR_REQ
  } state_t;

  // One bit per bus strobe; psen/rd/wr are active low, ale active high.
  typedef struct packed {
    logic ale;
    logic psen;
    logic rd;
    logic wr;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '{ale: 1'b0, psen: 1'b1, rd: 1'b1, wr: 1'b1};

  // True when more than one of the active-low data strobes is asserted.
  function automatic logic multi_low(input logic psen, input logic rd, input logic wr);
    return (!psen && !rd) || (!psen && !wr) || (!rd && !wr);
  endfunction

endpackage

// File: rtl/bus_edge_sync.sv
// Samples the bus strobes once per clock and produces single-cycle fall/rise pulses.
module bus_edge_sync
  import bus_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  strobes_t strobes,
  output strobes_t fall_c,
  output strobes_t rise_c
);

  strobes_t strobes_q;
  logic     armed;

  // armed suppresses edges in the first cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobes_q <= STROBES_IDLE;
      armed     <= 1'b0;
    end else begin
      strobes_q <= strobes;
      armed     <= 1'b1;
    end
  end

  assign fall_c = armed ? strobes_t'(strobes_q & ~strobes) : strobes_t'('0);
  assign rise_c = armed ? strobes_t'(~strobes_q & strobes) : strobes_t'('0);

endmodule

// File: rtl/ext_bus_responder.sv
// Slave end of the 8051 ALE/PSEN/RD/WR bus: latches addresses, bridges strobes
// into a req/ack backing-store handshake and drives read data back onto P0.
module ext_bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter logic [7:0]  IDLE_DATA = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ale,
  input  logic              psen,
  input  logic              rd,
  input  logic              wr,
  input  logic [7:0]        p0_in,
  input  logic [7:0]        p2_in,
  output logic [7:0]        p0_out,
  output logic              p0_oe,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_space,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  input  logic              err_clr,
  output logic              bus_err
);

  localparam int unsigned    CNT_W    = 4;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  strobes_t         raw_c;
  strobes_t         fall_c;
  strobes_t         rise_c;
  state_t           state;
  logic [7:0]       addr_hi;
  logic [7:0]       addr_lo;
  logic [CNT_W-1:0] tmo_cnt;
  logic             late;
  logic             src_low_c;
  logic             src_rise_c;
  logic             multi_low_c;
  logic             any_fall_c;
  logic             unused_ale_edges;

  assign raw_c = strobes_t'({ale, psen, rd, wr});

  bus_edge_sync u_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .strobes (raw_c),
    .fall_c  (fall_c),
    .rise_c  (rise_c)
  );

  // The address latch is level-driven by ale, so its edges are not needed.
  assign unused_ale_edges = fall_c.ale ^ rise_c.ale;

  // During a read, mem_space identifies which strobe started the access.
  assign src_low_c   = (mem_space == MEM_SPACE_XDATA) ? !rd : !psen;
  assign src_rise_c  = (mem_space == MEM_SPACE_XDATA) ? rise_c.rd : rise_c.psen;
  assign multi_low_c = multi_low(psen, rd, wr);
  assign any_fall_c  = fall_c.psen | fall_c.rd | fall_c.wr;

  // Transparent while ale is high, holds the last address once it falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_hi <= 8'h00;
      addr_lo <= 8'h00;
    end else if (ale) begin
      addr_hi <= p2_in;
      addr_lo <= p0_in;
    end
  end

  // Access FSM; error sets are written after err_clr so a set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      p0_out    <= 8'h00;
      p0_oe     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_space <= MEM_SPACE_CODE;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      bus_err   <= 1'b0;
      tmo_cnt   <= '0;
      late      <= 1'b0;
    end else begin
      if (err_clr) begin
        bus_err <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          p0_oe <= 1'b0;
          if (any_fall_c) begin
            if (multi_low_c) begin
              bus_err <= 1'b1;
            end else if (fall_c.psen || fall_c.rd) begin
              state     <= ST_RD_REQ;
              mem_space <= fall_c.rd ? MEM_SPACE_XDATA : MEM_SPACE_CODE;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= ADDR_W'({addr_hi, addr_lo});
              tmo_cnt   <= '0;
              late      <= 1'b0;
            end else begin
              state     <= ST_WR_CAPT;
              mem_wdata <= p0_in;
            end
          end
        end

        ST_RD_REQ: begin
          if (src_rise_c) begin
            late    <= 1'b1;
            bus_err <= 1'b1;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (late || !src_low_c) begin
              bus_err <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              p0_out <= mem_rdata;
              state  <= ST_RD_DRIVE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (!late && src_low_c) begin
              p0_out <= IDLE_DATA;
              state  <= ST_RD_DRIVE;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        ST_RD_DRIVE: begin
          if (src_low_c) begin
            p0_oe <= 1'b1;
          end else begin
            p0_oe <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_WR_CAPT: begin
          if (fall_c.psen) begin
            bus_err <= 1'b1;
          end
          if (rise_c.wr) begin
            state     <= ST_WR_REQ;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_space <= MEM_SPACE_XDATA;
            mem_addr  <= ADDR_W'({addr_hi, addr_lo});
            tmo_cnt   <= '0;
          end else if (!wr) begin
            mem_wdata <= p0_in;
          end
        end

        ST_WR_REQ: begin
          if (fall_c.psen) begin
            bus_err <= 1'b1;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ext_bus_responder.md
Name: ext_bus_responder

Overview:
- External-memory responder for the 8051 core's multiplexed bus: the slave end of the ALE/PSEN/RD/WR protocol the CPU control unit drives.
- Latches the address from P0/P2 on ALE, decodes the strobes into CODE reads, XDATA reads and XDATA writes, and bridges each into a req/ack backing-store handshake.
- Drives read data back onto P0 during PSEN/RD low. Sits outside the core, between the port pads and ROM/RAM models.

Parameters:
- ADDR_W, 16, bus address width; the high byte comes from P2, the low byte from P0.
- TIMEOUT, 15, maximum clk cycles to wait for mem_ack before abandoning an access; 4-bit counter.
- IDLE_DATA, 8'hFF, value returned on P0 after a timeout.

Ports:
- clk  in  1  system clock, same clock as the CPU; all bus inputs sampled on posedge.
- reset  in  1  asynchronous, active-low reset.
- ale  in  1  address latch enable, high pulse.
- psen  in  1  program strobe, active low.
- rd  in  1  XDATA read strobe, active low.
- wr  in  1  XDATA write strobe, active low.
- p0_in  in  8  P0 pad input (low address / write data).
- p2_in  in  8  P2 pad input (high address).
- p0_out  out  8  read data to P0.
- p0_oe  out  1  P0 output enable.
- mem_req  out  1  backing-store request, held until ack or timeout.
- mem_we  out  1  1 = write.
- mem_space  out  1  0 = CODE, 1 = XDATA.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge.
- err_clr  in  1  clears bus_err.
- bus_err  out  1  sticky protocol/timeout error.

Behaviour:
- Reset (reset=0, async): state IDLE; p0_out=0, p0_oe=0, mem_req=0, mem_we=0, mem_space=0, mem_addr=0, mem_wdata=0, bus_err=0; sampled strobes preset inactive (ale_q=0, psen_q=rd_q=wr_q=1).
- Edge detection:
  - One register stage per strobe.
  - Fall = q high and input low; rise = q low and input high.
  - No edge is recognised in the first cycle after reset release.
- Address latch:
  - Every cycle ale=1: addr_lo <= p0_in, addr_hi <= p2_in.
  - On ALE fall both freeze.
  - The address persists; a strobe with no new ALE reuses the last address (MOVX without ALE).
- FSM states: IDLE, RD_REQ, RD_DRIVE, WR_CAPT, WR_REQ.
  - IDLE:
    - psen fall alone -> RD_REQ, mem_space=0.
    - rd fall alone -> RD_REQ, mem_space=1.
    - wr fall alone -> WR_CAPT.
    - Any two strobes low together -> stay IDLE, bus_err=1, no request.
  - RD_REQ:
    - mem_req=1, mem_we=0, mem_addr={addr_hi,addr_lo}.
    - On mem_ack: data register <= mem_rdata, mem_req=0, -> RD_DRIVE.
  - RD_DRIVE: p0_out=data; p0_oe=1 while the originating strobe is low. On strobe rise: p0_oe=0 in the same cycle the rise is sampled, -> IDLE.
  - Strobe rises before ack (late read):
    - mem_req stays high until ack or timeout.
    - The data is discarded and P0 is never driven.
    - bus_err=1; -> IDLE.
  - WR_CAPT: mem_wdata <= p0_in every cycle wr is low. On wr rise -> WR_REQ (last low-cycle data is kept).
  - WR_REQ: mem_req=1, mem_we=1, mem_space=1, until mem_ack -> IDLE.
  - A psen fall during WR_CAPT/WR_REQ is a protocol error (bus_err=1); the write still completes.
- Timeout:
  - The counter clears on entry to RD_REQ/WR_REQ and increments each cycle without ack.
  - At TIMEOUT: mem_req=0, bus_err=1.
  - Read: data register = IDLE_DATA, -> RD_DRIVE if the strobe is still low, else IDLE.
  - Write: -> IDLE.
- Ack arriving in IDLE or RD_DRIVE is ignored.
- Read latency: strobe fall sampled at edge N -> mem_req high after edge N. With zero-wait ack (ack high the cycle after req), p0_oe is high after edge N+2.
- bus_err: set has priority over err_clr in the same cycle.
- Reset mid-access: all outputs return to reset values immediately; a pending request is dropped without ack.

Decomposition:
- Shared package (bus_pkg): state encoding, MEM_SPACE_CODE=0 / MEM_SPACE_XDATA=1, default TIMEOUT.
- One natural sub-module: bus_edge_sync. It holds the sampled-strobe registers and produces fall/rise pulses for ale, psen, rd, wr.
- FSM, address latch and timeout counter stay in the top.

Test Plan:
- Code fetch: ale high with p0=8'h34, p2=8'h12, falls; psen low 4 cycles; ack next cycle with rdata=8'hA5 -> mem_addr=16'h1234, mem_space=0, p0_out=8'hA5, p0_oe high until psen rises, bus_err=0.
- XDATA write: ALE addr 16'h0040, wr low 3 cycles with p0=8'h5A -> after wr rise, mem_req=1, mem_we=1, mem_space=1, mem_wdata=8'h5A; idle after ack.
- MOVX without ALE: rd fall with no new ALE after the write above -> mem_addr=16'h0040, mem_space=1, read data driven.
- Timeout: psen low 20 cycles, no ack -> mem_req drops after 15 cycles, p0_out=8'hFF driven, bus_err=1; err_clr clears it.
- Protocol error: psen and rd fall together -> no mem_req, bus_err=1; late read (ack after psen rise) -> p0_oe never high, bus_err=1.
- Reset mid-read: assert reset while mem_req=1 -> mem_req/p0_oe drop asynchronously; after release, a new fetch works normally.
